// File: rtl/ieee_pkg.sv
// Shared widths and the packed single-precision layout for the fixed-to-float converter.
package ieee_pkg;

    localparam int unsigned INT_W    = 5;
    localparam int unsigned FRAC_W   = 5;
    localparam int unsigned FIX_W    = INT_W + FRAC_W;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } ieee_float_t;

endpackage

// File: rtl/ieee_lzd.sv
// Combinational leading-one detector for the 10-bit fixed-point word.
module ieee_lzd
    import ieee_pkg::*;
(
    input  logic [FIX_W-1:0] i_word,
    output logic [3:0]       o_pos,
    output logic             o_zero
);

    always_comb begin
        o_pos  = '0;
        o_zero = 1'b1;
        // Ascending scan: the last hit is the most significant one.
        for (int unsigned i = 0; i < FIX_W; i++) begin
            if (i_word[i]) begin
                o_pos  = 4'(i);
                o_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ieee.sv
// Unsigned 5.5 fixed-point to IEEE-754 single converter, one register stage.
// Define IEEE_DEBUG_EN to drive the exponent/leading-one debug outputs temp/temp2.
module ieee
    import ieee_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INT_W-1:0]   in1,
    input  logic [FRAC_W-1:0]  in2,
    output logic               out_valid,
    output logic [31:0]        out,
    output logic [MAN_W-1:0]   mantissa,
    output logic [4:0]         temp,
    output logic [4:0]         temp2
);

    localparam logic [EXP_W-1:0] EXP_BASE = EXP_W'(EXP_BIAS - FRAC_W);

    logic [FIX_W-1:0] w_fix;
    logic [3:0]       w_pos;
    logic             w_zero;
    logic [FIX_W-1:0] w_norm;
    logic [4:0]       w_exp_unb;
    ieee_float_t      w_flt;

    ieee_float_t      r_flt;
    logic             r_valid;

    assign w_fix = {in1, in2};

    ieee_lzd u_lzd (
        .i_word (w_fix),
        .o_pos  (w_pos),
        .o_zero (w_zero)
    );

    // Shift the leading one up to bit FIX_W-1; the bits under it become the fraction.
    assign w_norm    = w_fix << (4'(FIX_W - 1) - w_pos);
    assign w_exp_unb = {1'b0, w_pos} - 5'(FRAC_W);

    always_comb begin
        w_flt = '0;
        if (!w_zero) begin
            w_flt.exp  = EXP_BASE + {4'b0, w_pos};
            w_flt.frac = {w_norm[FIX_W-2:0], {(MAN_W - FIX_W + 1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_flt <= w_flt;
            end
        end
    end

`ifdef IEEE_DEBUG_EN
    logic [4:0] r_temp;
    logic [4:0] r_temp2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_temp  <= '0;
            r_temp2 <= '0;
        end else if (in_valid) begin
            r_temp  <= w_zero ? 5'd0 : w_exp_unb;
            r_temp2 <= {1'b0, w_pos};
        end
    end

    assign temp  = r_temp;
    assign temp2 = r_temp2;
`else
    logic w_unused;
    assign w_unused = ^w_exp_unb;
    assign temp     = '0;
    assign temp2    = '0;
`endif

    assign out       = r_flt;
    assign mantissa  = r_flt.frac;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_ieee.sv
// Directed-vector bench for the fixed-to-float converter.
module tb_ieee;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in1;
    logic [4:0]  in2;
    logic        out_valid;
    logic [31:0] out;
    logic [22:0] mantissa;
    logic [4:0]  temp;
    logic [4:0]  temp2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ieee dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out       (out),
        .mantissa  (mantissa),
        .temp      (temp),
        .temp2     (temp2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Debug outputs are only live when the bench and RTL are built with IEEE_DEBUG_EN.
    task automatic check_res(input string tag, input logic [31:0] e_out,
                             input logic [4:0] e_t, input logic [4:0] e_t2);
        logic [4:0] et;
        logic [4:0] et2;
`ifdef IEEE_DEBUG_EN
        et  = e_t;
        et2 = e_t2;
`else
        et  = '0;
        et2 = '0;
`endif
        check({tag, ".out"},      out,                e_out);
        check({tag, ".mantissa"}, {9'b0, mantissa},   {9'b0, e_out[22:0]});
        check({tag, ".temp"},     {27'b0, temp},      {27'b0, et});
        check({tag, ".temp2"},    {27'b0, temp2},     {27'b0, et2});
        check({tag, ".valid"},    {31'b0, out_valid}, 32'd1);
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in1      = 5'd7;
        in2      = 5'd6;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out",   out,                32'h0);
        check("rst.man",   {9'b0, mantissa},   32'h0);
        check("rst.temp",  {27'b0, temp},      32'h0);
        check("rst.temp2", {27'b0, temp2},     32'h0);
        check("rst.valid", {31'b0, out_valid}, 32'h0);
        rst = 1'b0;

        drive(5'd0, 5'd0);
        check_res("zero", 32'h0000_0000, 5'd0, 5'd0);

        // Back-to-back: 7.1875 then 9.25 on consecutive edges.
        drive(5'd7, 5'd6);
        check_res("v7_6", 32'h40E6_0000, 5'd2, 5'd7);
        drive(5'd9, 5'd8);
        check_res("v9_8", 32'h4114_0000, 5'd3, 5'd8);

        drive(5'd1, 5'd0);
        check_res("one", 32'h3F80_0000, 5'd0, 5'd5);
        drive(5'd16, 5'd16);
        check_res("v16_16", 32'h4184_0000, 5'd4, 5'd9);
        drive(5'd0, 5'd1);
        check_res("min", 32'h3D00_0000, 5'b11011, 5'd0);
        drive(5'd31, 5'd31);
        check_res("max", 32'h41FF_C000, 5'd4, 5'd9);

        // Hold: inputs change but in_valid is low.
        in_valid = 1'b0;
        in1      = 5'd3;
        in2      = 5'd3;
        @(posedge clk);
        #1;
        check("hold.out",   out,                32'h41FF_C000);
        check("hold.valid", {31'b0, out_valid}, 32'h0);

        // Asynchronous clear between edges while a conversion is pending.
        in_valid = 1'b1;
        in1      = 5'd0;
        in2      = 5'd1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.out",   out,                32'h0);
        check("arst.valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("arst.held", out, 32'h0);
        rst = 1'b0;

        drive(5'd0, 5'd1);
        check_res("post_rst", 32'h3D00_0000, 5'b11011, 5'd0);

        in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
